// File: rtl/car_dash_ctrl.sv
// car_dash_ctrl: game-tick controller owning the obstacle board, car position and score
//   clk/rst          : clock, asynchronous active-high reset
//   start            : level, begins a new game from IDLE or DEAD
//   btn_left/right   : debounced move requests, latched between ticks
//   new_row          : obstacle row shifted into the far end of the board
//   move_result      : move unit result (3'b111 crash, else new column)
//   next_row/head_row: board rows 1 and 0, to the move unit
//   car_pos          : current car column
//   attempt_move     : 00 up, 10 left, 01 right
//   board            : flattened board, row r at [6r+5:6r]
//   alive/game_over  : game status, score: saturating survived ticks
module car_dash_ctrl #(
    parameter int ROWS     = 8,
    parameter int TICK_DIV = 25000000,
    parameter int INIT_POS = 2,
    parameter int SCORE_W  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic [5:0]          new_row,
    input  logic [2:0]          move_result,
    output logic [5:0]          next_row,
    output logic [5:0]          head_row,
    output logic [2:0]          car_pos,
    output logic [1:0]          attempt_move,
    output logic [6*ROWS-1:0]   board,
    output logic                alive,
    output logic                game_over,
    output logic [SCORE_W-1:0]  score
);
    localparam int CW = $clog2(TICK_DIV);
    typedef enum logic [2:0] {IDLE, RUN, EVAL, CHECK, DEAD} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic lat_l, lat_r, go_l, go_r, tick, crash;
    // a press in the very cycle the tick fires still counts
    assign go_l = lat_l | btn_left;
    assign go_r = lat_r | btn_right;
    assign tick = cnt == CW'(TICK_DIV - 1);
    // 6 never legitimately occurs, so it is treated as a crash too
    assign crash = &move_result[2:1];
    assign head_row = board[5:0];
    assign next_row = board[11:6];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            board        <= '0;
            car_pos      <= 3'(INIT_POS);
            score        <= '0;
            cnt          <= '0;
            lat_l        <= 1'b0;
            lat_r        <= 1'b0;
            attempt_move <= 2'b00;
            alive        <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            case (state)
                IDLE, DEAD: if (start) begin
                    state        <= RUN;
                    board        <= '0;
                    car_pos      <= 3'(INIT_POS);
                    score        <= '0;
                    cnt          <= '0;
                    lat_l        <= 1'b0;
                    lat_r        <= 1'b0;
                    attempt_move <= 2'b00;
                    alive        <= 1'b1;
                    game_over    <= 1'b0;
                end
                RUN: if (tick) begin
                    state        <= EVAL;
                    cnt          <= '0;
                    attempt_move <= {go_l & ~go_r, go_r & ~go_l};
                    lat_l        <= 1'b0;
                    lat_r        <= 1'b0;
                end else begin
                    cnt   <= cnt + 1'b1;
                    lat_l <= go_l;
                    lat_r <= go_r;
                end
                EVAL: state <= CHECK;
                CHECK: begin
                    attempt_move <= 2'b00;
                    if (crash) begin
                        state     <= DEAD;
                        alive     <= 1'b0;
                        game_over <= 1'b1;
                    end else begin
                        state   <= RUN;
                        car_pos <= move_result;
                        board   <= {new_row, board[6*ROWS-1:6]};
                        score   <= score + {{(SCORE_W-1){1'b0}}, ~&score};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/car_dash_ctrl.md
Name: car_dash_ctrl

Overview:
Game-tick controller for the Car Dash playfield. It owns the obstacle board and the car position, and paces the game with a tick prescaler. It latches player button presses between ticks and sequences the registered car-move/collision unit once per tick. It then consumes that unit's result to advance the board, score, or end the game. It sits between the button debouncers/obstacle generator and the 7-seg/display driver.

Parameters:
ROWS, 8, number of 6-bit board rows held (row 0 = car row, row 1 = next row); minimum 2
TICK_DIV, 25000000, clk cycles per game tick while running; minimum 2
INIT_POS, 2, car column after start (0..5; 0 = rightmost, 5 = leftmost)
SCORE_W, 10, score counter width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  level; starts a new game from IDLE or DEAD
btn_left  input  1  debounced left request, level
btn_right  input  1  debounced right request, level
new_row  input  6  obstacle row from generator, sampled on board shift
move_result  input  3  registered result from move unit (3'b111 = crash, else new column)
next_row  output  6  board row 1, to move unit
head_row  output  6  board row 0, to move unit
car_pos  output  3  current car column, to move unit
attempt_move  output  2  00 = up, 10 = left, 01 = right; 11 never driven
board  output  6*ROWS  flattened board, row r at bits [6r+5:6r]
alive  output  1  1 in RUN/EVAL/CHECK
game_over  output  1  1 in DEAD
score  output  SCORE_W  successful ticks survived, saturating

Behaviour:
- Reset (async, immediate):
  - state = IDLE; board = 0; car_pos = INIT_POS; score = 0.
  - tick counter = 0; move latches cleared; attempt_move = 00; alive = 0; game_over = 0.
- States:
  - IDLE -> RUN when start = 1.
  - RUN -> EVAL when the tick counter reaches TICK_DIV-1.
  - EVAL -> CHECK unconditionally.
  - CHECK -> RUN or DEAD, depending on the result.
  - DEAD -> RUN when start = 1.
- Start from IDLE or DEAD:
  - Clears board, score, tick counter and latches; car_pos = INIT_POS.
  - The first tick occurs TICK_DIV cycles after entering RUN.
- RUN:
  - Tick counter increments each cycle and wraps to 0 on entering EVAL.
  - btn_left sets a sticky L latch; btn_right sets a sticky R latch.
- RUN -> EVAL transition sets attempt_move:
  - L only -> 10.
  - R only -> 01.
  - Neither, or both -> 00.
  - L and R latches cleared in the same cycle.
- Latch timing: a press in the RUN->EVAL cycle itself is captured; presses during EVAL/CHECK are ignored.
- EVAL (1 cycle):
  - next_row, head_row, car_pos and attempt_move are stable, so the move unit registers them at the end of EVAL.
  - These outputs must stay unchanged through CHECK.
- CHECK (1 cycle): move_result is valid and sampled at the end of CHECK.
  - 3'b111 -> DEAD; board, car_pos and score are frozen.
  - Otherwise:
    - car_pos <= move_result.
    - Board shifts toward the car: row r <= row r+1 for r < ROWS-1; row ROWS-1 <= new_row.
    - score increments, saturating at all-ones.
    - Return to RUN.
- Result range: move_result values 6 and 7 other than crash cannot occur. If 6 is seen, treat it as crash (defensive).
- attempt_move returns to 00 on entering RUN or DEAD.
- Tick latency: TICK_DIV cycles in RUN, plus EVAL, plus CHECK, gives a period of TICK_DIV+2 cycles.
- start while in RUN/EVAL/CHECK is ignored; the game runs until a crash.
- Held start in DEAD restarts immediately next cycle.
- rst mid-tick (any state) aborts to IDLE with all reset values, with no partial board shift.

Test Plan:
- Reset mid-CHECK -> alive = 0, board = 0, car_pos = INIT_POS, score = 0 immediately.
- TICK_DIV=4, ROWS=4, start, no buttons, new_row = 6'b000000, move_result echoes 2 -> attempt_move = 00 each EVAL; score = 1, 2, 3 at cycles 6, 12, 18 after RUN entry; car_pos = 2.
- btn_left pulsed 1 cycle mid-RUN, move_result = 3 -> attempt_move = 10 in EVAL/CHECK; car_pos = 3 after CHECK; latches clear, so the next tick is 00.
- btn_left and btn_right both pulsed in one tick -> attempt_move = 00.
- new_row = 6'b000100 fed for ROWS ticks -> row 0 = 6'b000100; move_result = 3'b111 -> DEAD, game_over = 1, score frozen; start -> RUN with board = 0, score = 0.
- Force score to max via 2^SCORE_W successful ticks (SCORE_W = 3) -> score holds 7.
